mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares the single-ported unified memory between the instruction-fetch port and the pipeline memory-stage data port.
- Each side issues a level request and holds it until acked.
- The arbiter picks a winner, drives a req/ready memory handshake, and returns read data with a one-cycle ack.
- Provides starvation protection for fetch, a watchdog timeout and a sticky error flag.

Parameters:
- ADDR_W, 30, word address width (byte address [31:2])
- DATA_W, 32, data width
- STARVE_LIMIT, 4, consecutive contested data grants before fetch is forced to win
- TIMEOUT, 255, max cycles waiting for mem_ready before abort (8-bit counter)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-low
- if_req  in  1  fetch read request, level, held until if_ack
- if_addr  in  ADDR_W  fetch word address
- if_rdata  out  DATA_W  fetch read data, valid while if_ack=1
- if_ack  out  1  one-cycle fetch completion pulse
- d_read  in  1  data read request, level
- d_write  in  1  data write request, level
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_be  in  4  store byte enables
- d_rdata  out  DATA_W  load data, valid while d_ack=1
- d_ack  out  1  one-cycle data completion pulse
- mem_req  out  1  memory request
- mem_we  out  1  1=write, 0=read
- mem_addr  out  ADDR_W  memory word address
- mem_wdata  out  DATA_W  memory write data
- mem_be  out  4  memory byte enables (4'hF on reads)
- mem_ready  in  1  memory completes transaction this cycle
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- bus_err  out  1  sticky timeout/conflict flag, cleared only by reset

Behaviour:
- Reset (async, any state, mid-transaction included):
  - State goes to IDLE.
  - All outputs 0: mem_req, mem_we, mem_addr, mem_wdata, mem_be, if_ack, d_ack, if_rdata, d_rdata, bus_err.
  - Starve and timeout counters 0.
  - mem_req drops immediately, without waiting for a clock edge.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Samples requests; d_req = d_read | d_write.
  - No request: stay in IDLE.
  - Winner selection:
    - Only one side requesting: that side wins.
    - Both requesting: data wins, unless starve_cnt == STARVE_LIMIT, in which case fetch wins.
  - On a winner, register the command into the mem_* outputs, set mem_req=1 and go to BUSY.
  - starve_cnt increments on a contested data win, saturating at STARVE_LIMIT. It clears to 0 on any fetch grant.
- d_read and d_write both high: treated as a write, and bus_err is set.
- BUSY:
  - mem_req=1 with mem_addr, mem_we, mem_wdata and mem_be stable.
  - Each cycle: mem_ready=1 completes the transaction. Otherwise wait_cnt increments.
  - On mem_ready:
    - Read: capture mem_rdata into the winner's rdata register.
    - Clear mem_req and go to DONE.
  - wait_cnt == TIMEOUT without mem_ready is an abort:
    - Clear mem_req, load rdata with 0, set bus_err, go to DONE.
- DONE:
  - Lasts exactly one cycle.
  - Asserts the winner's ack (if_ack or d_ack), never both.
  - rdata holds its value until the next completion to that port.
  - Then go to IDLE. Requesters update their request on the edge ending DONE, so IDLE never re-grants a stale request.
- Latency:
  - Request seen in IDLE at cycle 0; mem_req is high in cycle 1.
  - mem_ready in cycle 1+k gives the ack in cycle 2+k.
  - Minimum 3 cycles per transaction.
- Writes: ack is pulsed and d_rdata is unchanged.
- The fetch path never asserts mem_we.
- Request deasserted during BUSY: ignored; the transaction completes and the ack is still pulsed.
- Timeout boundary: mem_ready in the same cycle wait_cnt reaches TIMEOUT is a normal completion, not an abort.

Decomposition:
- Package mem_arb_pkg:
  - state_t enum (IDLE, BUSY, DONE)
  - grant_t enum (GNT_IF, GNT_D)
  - ADDR_W/DATA_W defaults
  - BE_ALL = 4'hF
- Sub-module arb_wait_counter (clear, enable, limit compare, terminal flag) is natural; reused for starve_cnt and wait_cnt.

Test Plan:
- if_req=1, if_addr=30'h10; mem_ready=1 in cycle 1 with mem_rdata=32'hDEADBEEF -> mem_req in cycle 1 with mem_we=0 and mem_be=F; if_ack and if_rdata=DEADBEEF in cycle 2; d_ack stays 0.
- d_write=1, d_addr=30'h20, d_wdata=32'h12345678, d_be=4'b0011; mem_ready after 3 wait cycles -> mem_we=1, mem_be=0011 stable all 4 BUSY cycles; d_ack 1 cycle after mem_ready; d_rdata unchanged.
- if_req and d_read held continuously; mem_ready always 1 -> grant order D,D,D,D,IF,D,D,D,D,IF.
- mem_ready tied 0 on a d_read -> mem_req drops after 255 wait cycles; d_ack pulses with d_rdata=0; bus_err=1 and stays 1.
- rst low for 1 cycle mid-BUSY -> mem_req=0 immediately, FSM IDLE, no ack; next request is served normally.
- d_read=d_write=1 -> write issued (mem_we=1) and bus_err=1.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the fetch/data memory port arbiter.
package mem_arb_pkg;
  localparam int DEF_ADDR_W = 30;
  localparam int DEF_DATA_W = 32;
  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  typedef enum logic {GNT_IF, GNT_D} grant_t;
endpackage

// File: rtl/arb_wait_counter.sv
// Saturating up-counter with synchronous clear and a terminal flag at LIMIT.
module arb_wait_counter #(
  parameter int W     = 8,
  parameter int LIMIT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic at_limit
);
  logic [W-1:0] cnt;

  assign at_limit = (cnt == W'(LIMIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      cnt <= '0;
    else if (clr)
      cnt <= '0;
    else if (en && !at_limit)
      cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified single-ported memory between instruction fetch and the
// data port, with fetch starvation protection, a wait watchdog and a sticky error.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
);
  localparam int WAIT_W   = $clog2(TIMEOUT + 1);
  localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);

  state_t state_q, state_d;
  grant_t grant_q;
  logic   d_req, win_if, win_d;
  logic   starve_at_limit, wait_at_limit;
  logic   finish;

  // Fetch wins an uncontested request, or a contested one once data has hogged the port.
  always_comb begin
    d_req   = d_read | d_write;
    win_if  = if_req & (~d_req | starve_at_limit);
    win_d   = d_req & ~win_if;
    finish  = mem_ready | wait_at_limit;
    state_d = state_q;
    case (state_q)
      IDLE:    if (if_req || d_req) state_d = BUSY;
      BUSY:    if (finish) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  arb_wait_counter #(.W(STARVE_W), .LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q == IDLE && win_if),
    .en       (state_q == IDLE && win_d && if_req),
    .at_limit (starve_at_limit)
  );

  arb_wait_counter #(.W(WAIT_W), .LIMIT(TIMEOUT)) u_wait (
    .clk      (clk),
    .rst      (rst),
    .clr      (state_q != BUSY),
    .en       (state_q == BUSY && !mem_ready),
    .at_limit (wait_at_limit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
      bus_err   <= 1'b0;
      grant_q   <= GNT_IF;
    end else begin
      if_ack <= 1'b0;
      d_ack  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_if) begin
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= BE_ALL;
            grant_q   <= GNT_IF;
          end else if (win_d) begin
            // A simultaneous read+write is resolved as the write and flagged.
            mem_req   <= 1'b1;
            mem_we    <= d_write;
            mem_addr  <= d_addr;
            mem_wdata <= d_write ? d_wdata : '0;
            mem_be    <= d_write ? d_be : BE_ALL;
            grant_q   <= GNT_D;
            if (d_read && d_write) bus_err <= 1'b1;
          end
        end
        BUSY: begin
          if (finish) begin
            mem_req <= 1'b0;
            if_ack  <= (grant_q == GNT_IF);
            d_ack   <= (grant_q == GNT_D);
            if (!mem_ready) bus_err <= 1'b1;
            if (!mem_we) begin
              if (grant_q == GNT_IF) if_rdata <= mem_ready ? mem_rdata : '0;
              else                   d_rdata  <= mem_ready ? mem_rdata : '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed, table-driven bench for mem_port_arbiter plus hand-written corner sequences.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_read, d_write, mem_ready;
  logic [29:0] if_addr, d_addr;
  logic [31:0] d_wdata, mem_rdata;
  logic [3:0]  d_be;
  logic [31:0] if_rdata, d_rdata, mem_wdata;
  logic        if_ack, d_ack, mem_req, mem_we, bus_err;
  logic [29:0] mem_addr;
  logic [3:0]  mem_be;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mem_port_arbiter dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_ready(mem_ready), .mem_rdata(mem_rdata), .bus_err(bus_err)
  );

  typedef struct {
    logic        ifr;
    logic [29:0] ifa;
    logic        dr;
    logic        dw;
    logic [29:0] da;
    logic [31:0] dwd;
    logic [3:0]  dbe;
    logic [31:0] mrd;
    int          waits;
    logic        we;
    logic [29:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        eia;
    logic        eda;
    logic [31:0] eifr;
    logic [31:0] edr;
    logic        eerr;
  } vec_t;

  vec_t tbl[6];
  vec_t v;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; d_read = 0; d_write = 0; mem_ready = 0;
  endtask

  // Issue one request from IDLE, complete it after v.waits wait cycles, check every phase.
  task automatic run_txn(input vec_t t, input string tag);
    logic ok;
    if_req = t.ifr; if_addr = t.ifa; d_read = t.dr; d_write = t.dw;
    d_addr = t.da; d_wdata = t.dwd; d_be = t.dbe; mem_ready = 0;
    tick();
    chk({tag, "_req"}, mem_req, 1);
    chk({tag, "_we"}, mem_we, t.we);
    chk({tag, "_addr"}, mem_addr, t.addr);
    chk({tag, "_be"}, mem_be, t.be);
    chk({tag, "_wdata"}, mem_wdata, t.wdata);
    ok = 1;
    for (int k = 0; k <= t.waits; k++) begin
      if (mem_req !== 1 || mem_we !== t.we || mem_addr !== t.addr || mem_be !== t.be ||
          mem_wdata !== t.wdata || if_ack !== 0 || d_ack !== 0) ok = 0;
      mem_ready = (k == t.waits);
      mem_rdata = (k == t.waits) ? t.mrd : 32'hBAD0BAD0;
      tick();
    end
    chk({tag, "_busy_hold"}, ok, 1);
    chk({tag, "_req_drop"}, mem_req, 0);
    chk({tag, "_acks"}, {if_ack, d_ack}, {t.eia, t.eda});
    chk({tag, "_if_rdata"}, if_rdata, t.eifr);
    chk({tag, "_d_rdata"}, d_rdata, t.edr);
    chk({tag, "_err"}, bus_err, t.eerr);
    idle_inputs();
    tick();
    chk({tag, "_ack_pulse"}, {if_ack, d_ack}, 2'b00);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n;
    logic ok;
    logic exp_if;

    //        ifr ifa      dr dw da           dwd           dbe    mrd           w    we addr         be     wdata         ia da ifr           dr            err
    tbl[0] = '{1, 30'h10, 0, 0, 30'h0,       32'h0,        4'h0,  32'hDEADBEEF, 0,   0, 30'h10,      4'hF,  32'h0,        1, 0, 32'hDEADBEEF, 32'h0,        0};
    tbl[1] = '{0, 30'h0,  0, 1, 30'h20,      32'h12345678, 4'h3,  32'hFFFFFFFF, 3,   1, 30'h20,      4'h3,  32'h12345678, 0, 1, 32'hDEADBEEF, 32'h0,        0};
    tbl[2] = '{0, 30'h0,  1, 0, 30'h3FFFFFFF, 32'h0,       4'h0,  32'hCAFEF00D, 1,   0, 30'h3FFFFFFF, 4'hF, 32'h0,        0, 1, 32'hDEADBEEF, 32'hCAFEF00D, 0};
    tbl[3] = '{1, 30'h0,  0, 0, 30'h0,       32'h0,        4'h0,  32'h00000001, 2,   0, 30'h0,       4'hF,  32'h0,        1, 0, 32'h00000001, 32'hCAFEF00D, 0};
    tbl[4] = '{0, 30'h0,  0, 1, 30'h7,       32'hA5A5A5A5, 4'h8,  32'hEEEEEEEE, 0,   1, 30'h7,       4'h8,  32'hA5A5A5A5, 0, 1, 32'h00000001, 32'hCAFEF00D, 0};
    tbl[5] = '{0, 30'h0,  1, 0, 30'h15,      32'h0,        4'h0,  32'h13579BDF, 255, 0, 30'h15,      4'hF,  32'h0,        0, 1, 32'h00000001, 32'h13579BDF, 0};

    rst = 0; idle_inputs();
    if_addr = 0; d_addr = 0; d_wdata = 0; d_be = 0; mem_rdata = 0;
    tick();
    chk("reset_mem", {mem_req, mem_we, mem_addr, mem_be}, 0);
    chk("reset_acks_err", {if_ack, d_ack, bus_err}, 0);
    chk("reset_rdata", {if_rdata, d_rdata}, 0);
    tick();
    rst = 1;
    tick();

    for (int i = 0; i < 6; i++) run_txn(tbl[i], $sformatf("vec%0d", i));

    // Both sides held with an always-ready memory: D,D,D,D,IF repeating.
    if_req = 1; if_addr = 30'h40; d_read = 1; d_write = 0; d_addr = 30'h41;
    mem_ready = 1; mem_rdata = 32'h77;
    n = 0;
    for (int c = 0; c < 100 && n < 10; c++) begin
      tick();
      if (if_ack || d_ack) begin
        exp_if = (n == 4 || n == 9);
        chk($sformatf("starve_grant%0d", n), {if_ack, d_ack}, exp_if ? 2'b10 : 2'b01);
        n++;
        if (n == 10) idle_inputs();
      end
    end
    chk("starve_count", n, 10);
    idle_inputs();
    tick();

    // Asynchronous reset in the middle of a transaction.
    d_read = 1; d_addr = 30'h9;
    tick();
    chk("midrst_req_before", mem_req, 1);
    #2 rst = 0;
    #1;
    chk("midrst_req_async", mem_req, 0);
    chk("midrst_rdata", {if_rdata, d_rdata}, 0);
    d_read = 0;
    @(posedge clk); #1;
    rst = 1;
    ok = 1;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (mem_req !== 0 || if_ack !== 0 || d_ack !== 0) ok = 0;
    end
    chk("midrst_quiet", ok, 1);
    v = '{1, 30'h2A, 0, 0, 30'h0, 32'h0, 4'h0, 32'h600DF00D, 1, 0, 30'h2A, 4'hF, 32'h0, 1, 0, 32'h600DF00D, 32'h0, 0};
    run_txn(v, "post_rst");

    // Read and write together: issued as a write and flagged.
    d_read = 1; d_write = 1; d_addr = 30'h5; d_wdata = 32'h11112222; d_be = 4'h6;
    tick();
    chk("conflict_we", {mem_we, mem_be, mem_wdata}, {1'b1, 4'h6, 32'h11112222});
    chk("conflict_err", bus_err, 1);
    mem_ready = 1; mem_rdata = 32'h99999999;
    tick();
    chk("conflict_ack", {if_ack, d_ack}, 2'b01);
    chk("conflict_d_rdata", d_rdata, 0);
    idle_inputs();
    tick();
    chk("conflict_err_sticky", bus_err, 1);

    rst = 0;
    #1 chk("err_cleared_by_rst", bus_err, 0);
    @(posedge clk); #1;
    rst = 1;
    tick();

    v = '{0, 30'h0, 1, 0, 30'h1, 32'h0, 4'h0, 32'h55AA55AA, 0, 0, 30'h1, 4'hF, 32'h0, 0, 1, 32'h0, 32'h55AA55AA, 0};
    run_txn(v, "pre_timeout");

    // Memory never answers: abort after the wait counter reaches its limit.
    d_read = 1; d_addr = 30'h11; mem_ready = 0; mem_rdata = 32'hFFFFFFFF;
    tick();
    n = 0;
    for (int c = 0; c < 400 && mem_req; c++) begin
      n++;
      if (c == 1) d_read = 0;
      tick();
    end
    chk("timeout_busy_cycles", n, 256);
    chk("timeout_ack", {if_ack, d_ack}, 2'b01);
    chk("timeout_d_rdata", d_rdata, 0);
    chk("timeout_err", bus_err, 1);
    idle_inputs();
    tick();
    chk("timeout_err_sticky", {bus_err, d_ack, mem_req}, 3'b100);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
